// File: rtl/uart_rx_frame_assembler.sv
// UART RX frame assembler: consumes one voted bit per bit period, tracks
// start/data/parity/stop position, deserializes LSB-first and flags errors.
// Optional error counter (err_cnt, err_cnt_clr) enabled by UART_RX_ERR_CNT_EN.
module uart_rx_frame_assembler #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_start,
  input  logic                  bit_strobe,
  input  logic                  sampled_bit,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err,
  output logic                  start_glitch
`ifdef UART_RX_ERR_CNT_EN
  ,
  input  logic                  err_cnt_clr,
  output logic [7:0]            err_cnt
`endif
);

  localparam int unsigned IDX_W = $clog2(DATA_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [IDX_W-1:0]      r_bit_idx;
  logic                  r_par_en;
  logic                  r_par_typ;
  logic                  r_par_flag;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic                  r_data_valid;
  logic                  r_par_err;
  logic                  r_stp_err;
  logic                  r_start_glitch;

  state_t                w_state_nxt;
  logic [DATA_WIDTH-1:0] w_shift_nxt;
  logic [IDX_W-1:0]      w_bit_idx_nxt;
  logic                  w_par_en_nxt;
  logic                  w_par_typ_nxt;
  logic                  w_par_flag_nxt;
  logic [DATA_WIDTH-1:0] w_data_out_nxt;
  logic                  w_data_valid_nxt;
  logic                  w_par_err_nxt;
  logic                  w_stp_err_nxt;
  logic                  w_start_glitch_nxt;
  logic                  w_par_expected;

  // Parity the received data should carry: even -> XOR of data, odd -> inverted
  assign w_par_expected = (^r_shift) ^ r_par_typ;

  // State and datapath register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_shift        <= '0;
      r_bit_idx      <= '0;
      r_par_en       <= 1'b0;
      r_par_typ      <= 1'b0;
      r_par_flag     <= 1'b0;
      r_data_out     <= '0;
      r_data_valid   <= 1'b0;
      r_par_err      <= 1'b0;
      r_stp_err      <= 1'b0;
      r_start_glitch <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_shift        <= w_shift_nxt;
      r_bit_idx      <= w_bit_idx_nxt;
      r_par_en       <= w_par_en_nxt;
      r_par_typ      <= w_par_typ_nxt;
      r_par_flag     <= w_par_flag_nxt;
      r_data_out     <= w_data_out_nxt;
      r_data_valid   <= w_data_valid_nxt;
      r_par_err      <= w_par_err_nxt;
      r_stp_err      <= w_stp_err_nxt;
      r_start_glitch <= w_start_glitch_nxt;
    end
  end

  // Next-state and next-output logic; pulses default low, storage holds
  always_comb begin
    w_state_nxt        = r_state;
    w_shift_nxt        = r_shift;
    w_bit_idx_nxt      = r_bit_idx;
    w_par_en_nxt       = r_par_en;
    w_par_typ_nxt      = r_par_typ;
    w_par_flag_nxt     = r_par_flag;
    w_data_out_nxt     = r_data_out;
    w_data_valid_nxt   = 1'b0;
    w_par_err_nxt      = 1'b0;
    w_stp_err_nxt      = 1'b0;
    w_start_glitch_nxt = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        // A strobe coincident with frame_start is not consumed here
        if (frame_start) begin
          w_state_nxt    = S_START;
          w_par_en_nxt   = par_en;
          w_par_typ_nxt  = par_typ;
          w_par_flag_nxt = 1'b0;
        end
      end

      S_START: begin
        if (bit_strobe) begin
          if (sampled_bit) begin
            w_state_nxt        = S_IDLE;
            w_start_glitch_nxt = 1'b1;
          end else begin
            w_state_nxt   = S_DATA;
            w_bit_idx_nxt = '0;
          end
        end
      end

      S_DATA: begin
        if (bit_strobe) begin
          w_shift_nxt = {sampled_bit, r_shift[DATA_WIDTH-1:1]};
          if (r_bit_idx == IDX_W'(DATA_WIDTH - 1)) begin
            w_bit_idx_nxt = '0;
            w_state_nxt   = r_par_en ? S_PARITY : S_STOP;
          end else begin
            w_bit_idx_nxt = r_bit_idx + IDX_W'(1);
          end
        end
      end

      S_PARITY: begin
        if (bit_strobe) begin
          w_par_flag_nxt = (sampled_bit != w_par_expected);
          w_state_nxt    = S_STOP;
        end
      end

      S_STOP: begin
        // frame_start arriving with the stop strobe is dropped
        if (bit_strobe) begin
          w_stp_err_nxt  = ~sampled_bit;
          w_par_err_nxt  = r_par_flag;
          if (sampled_bit && !r_par_flag) begin
            w_data_out_nxt   = r_shift;
            w_data_valid_nxt = 1'b1;
          end
          w_par_flag_nxt = 1'b0;
          w_state_nxt    = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign busy         = (r_state != S_IDLE);
  assign data_out     = r_data_out;
  assign data_valid   = r_data_valid;
  assign par_err      = r_par_err;
  assign stp_err      = r_stp_err;
  assign start_glitch = r_start_glitch;

`ifdef UART_RX_ERR_CNT_EN
  logic [7:0] r_err_cnt;

  // Saturating count of error-pulse cycles; clear beats increment
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_cnt <= 8'h00;
    end else if (err_cnt_clr) begin
      r_err_cnt <= 8'h00;
    end else if ((r_par_err | r_stp_err | r_start_glitch) && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'h01;
    end
  end

  assign err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_uart_rx_frame_assembler.sv
// Self-checking bench for uart_rx_frame_assembler: directed frames followed
// by randomized frames checked against a frame-level reference model.
module tb_uart_rx_frame_assembler;

  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          frame_start;
  logic          bit_strobe;
  logic          sampled_bit;
  logic          par_en;
  logic          par_typ;
  logic          busy;
  logic [DW-1:0] data_out;
  logic          data_valid;
  logic          par_err;
  logic          stp_err;
  logic          start_glitch;
`ifdef UART_RX_ERR_CNT_EN
  logic          err_cnt_clr;
  logic [7:0]    err_cnt;
`endif

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_data;
  int exp_cnt;

  uart_rx_frame_assembler #(.DATA_WIDTH(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .frame_start  (frame_start),
    .bit_strobe   (bit_strobe),
    .sampled_bit  (sampled_bit),
    .par_en       (par_en),
    .par_typ      (par_typ),
    .busy         (busy),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .par_err      (par_err),
    .stp_err      (stp_err),
    .start_glitch (start_glitch)
`ifdef UART_RX_ERR_CNT_EN
    ,
    .err_cnt_clr  (err_cnt_clr),
    .err_cnt      (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bump_cnt(input logic any_err);
    if (any_err && exp_cnt < 255) exp_cnt++;
  endtask

  // Random idle cycles between strobes; FSM must stay busy and silent
  task automatic gap();
    int n;
    n = $urandom_range(0, 2);
    repeat (n) begin
      tick();
      chk("busy_gap", 32'(busy), 32'd1);
    end
  endtask

  task automatic strobe(input logic b);
    gap();
    bit_strobe  = 1'b1;
    sampled_bit = b;
    tick();
    bit_strobe  = 1'b0;
    sampled_bit = $urandom;
  endtask

  // One frame; flip corrupts the parity bit, noise exercises ignored inputs
  task automatic send_frame(input logic [DW-1:0] d, input logic pen, input logic ptyp,
                            input logic start_b, input logic flip, input logic stop_b,
                            input logic noise, input logic fs_with_strobe);
    logic pbit;
    logic e_pe;
    logic e_se;
    logic e_ok;
    frame_start = 1'b1;
    par_en      = pen;
    par_typ     = ptyp;
    if (fs_with_strobe) begin
      bit_strobe  = 1'b1;
      sampled_bit = 1'b1;
    end
    tick();
    frame_start = 1'b0;
    bit_strobe  = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("no_glitch_on_start", 32'(start_glitch), 32'd0);
    if (noise) begin
      par_en  = $urandom;
      par_typ = $urandom;
    end
    strobe(start_b);
    if (start_b) begin
      chk("glitch_pulse", 32'(start_glitch), 32'd1);
      chk("glitch_busy", 32'(busy), 32'd0);
      chk("glitch_valid", 32'(data_valid), 32'd0);
      chk("glitch_data", 32'(data_out), 32'(exp_data));
      bump_cnt(1'b1);
      tick();
      chk("glitch_end", 32'(start_glitch), 32'd0);
`ifdef UART_RX_ERR_CNT_EN
      chk("err_cnt_glitch", 32'(err_cnt), 32'(exp_cnt));
`endif
      return;
    end
    for (int i = 0; i < int'(DW); i++) begin
      strobe(d[i]);
      if (noise && i == 3) begin
        frame_start = 1'b1;
        par_en      = ~pen;
        tick();
        frame_start = 1'b0;
        chk("busy_noise", 32'(busy), 32'd1);
      end
    end
    if (pen) begin
      pbit = ($countones(d) % 2 == 1) ^ ptyp ^ flip;
      strobe(pbit);
    end
    gap();
    bit_strobe  = 1'b1;
    sampled_bit = stop_b;
    frame_start = noise;
    tick();
    bit_strobe  = 1'b0;
    frame_start = 1'b0;
    e_pe = pen & flip;
    e_se = ~stop_b;
    e_ok = !e_pe && !e_se;
    if (e_ok) exp_data = d;
    chk("valid", 32'(data_valid), 32'(e_ok));
    chk("par_err", 32'(par_err), 32'(e_pe));
    chk("stp_err", 32'(stp_err), 32'(e_se));
    chk("data_out", 32'(data_out), 32'(exp_data));
    chk("busy_end", 32'(busy), 32'd0);
    bump_cnt(e_pe | e_se);
    tick();
    chk("valid_1cyc", 32'(data_valid), 32'd0);
    chk("par_err_1cyc", 32'(par_err), 32'd0);
    chk("stp_err_1cyc", 32'(stp_err), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
`ifdef UART_RX_ERR_CNT_EN
    chk("err_cnt", 32'(err_cnt), 32'(exp_cnt));
`endif
  endtask

  initial begin
    logic [DW-1:0] rd;
    rst = 1'b1; frame_start = 1'b0; bit_strobe = 1'b0; sampled_bit = 1'b0;
    par_en = 1'b0; par_typ = 1'b0;
`ifdef UART_RX_ERR_CNT_EN
    err_cnt_clr = 1'b0;
`endif
    exp_data = '0;
    exp_cnt  = 0;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_data", 32'(data_out), 32'd0);
    chk("rst_valid", 32'(data_valid), 32'd0);
    chk("rst_errs", 32'({par_err, stp_err, start_glitch}), 32'd0);

    // IDLE ignores strobes
    bit_strobe = 1'b1; sampled_bit = 1'b1;
    tick();
    bit_strobe = 1'b0;
    chk("idle_strobe_busy", 32'(busy), 32'd0);
    chk("idle_strobe_glitch", 32'(start_glitch), 32'd0);

    // 1: no parity, 0xA5
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    // 2: even parity good, then bad parity keeps data
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    // 3: odd parity wrong and stop bit 0 together
    send_frame(8'h01, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    // 4: start glitch, then a clean 0x55 frame
    send_frame(8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // 5: reset mid-frame after 4 data bits of 0xFF
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    strobe(1'b0);
    for (int i = 0; i < 4; i++) strobe(1'b1);
    rst = 1'b1; tick(); rst = 1'b0;
    exp_data = '0;
    exp_cnt  = 0;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_data", 32'(data_out), 32'd0);
    chk("midrst_pulses", 32'({data_valid, par_err, stp_err, start_glitch}), 32'd0);
`ifdef UART_RX_ERR_CNT_EN
    chk("midrst_cnt", 32'(err_cnt), 32'd0);
`endif
    send_frame(8'h0F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // 6: mid-frame par_en toggle and frame_start ignored
    send_frame(8'hC3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    // frame_start with a strobe in IDLE: strobe not consumed
    send_frame(8'h96, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

    // Randomized frames
    for (int k = 0; k < 40; k++) begin
      rd = DW'($urandom);
      send_frame(rd, 1'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0),
                 1'($urandom), 1'($urandom));
    end

`ifdef UART_RX_ERR_CNT_EN
    // Saturation, then clear
    for (int k = 0; k < 260; k++)
      send_frame(8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("err_cnt_sat", 32'(err_cnt), 32'hFF);
    err_cnt_clr = 1'b1; tick(); err_cnt_clr = 1'b0;
    exp_cnt = 0;
    chk("err_cnt_clr", 32'(err_cnt), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
